rv_muldiv_seq: RTL and testbench

Iterative M-extension sequencer for the execute stage. It accepts one MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU request with a valid/ready handshake. It runs a shared 33-bit add/subtract unit for 32 iterations, applies sign fix-up, and holds the result until writeback accepts it. The ALU stage stalls on o_ready low whenever it sees a muldiv-group instruction.

---
 rtl/rv_muldiv_seq.sv | 160 ++++++++++++++++
 tb/tb_rv_muldiv_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: one shared 33-bit add/sub unit,
// 32 iterations per operation, sign fix-up, and a result held until writeback takes it.
module rv_muldiv_seq #(
  parameter int unsigned EXTENSION_M      = 1,
  parameter int unsigned IADDR_SPACE_BITS = 32
) (
  input  logic                        i_clk,
  input  logic                        i_reset_n,
  input  logic                        i_flush,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [2:0]                  i_funct3,
  input  logic [31:0]                 i_op1,
  input  logic [31:0]                 i_op2,
  input  logic [4:0]                  i_rd,
  input  logic [IADDR_SPACE_BITS-1:0] i_pc,
  output logic                        o_valid,
  input  logic                        i_res_ready,
  output logic [31:0]                 o_result,
  output logic [4:0]                  o_rd,
  output logic [IADDR_SPACE_BITS-1:0] o_pc,
  output logic                        o_busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned AW    = XLEN + 1;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          funct3_q;
  logic [2*XLEN-1:0]   acc;       // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [XLEN-1:0]     opb_q;     // multiplicand for MUL*, divisor for DIV*
  logic                neg_q;
  logic                rem_neg_q;

  logic                op1_signed, op2_signed, sgn1, sgn2;
  logic [XLEN-1:0]     abs1, abs2;
  logic                div_zero, div_ovf, req_special;
  logic [XLEN-1:0]     special_res;

  logic                is_div;
  logic [AW-1:0]       add_a, add_b, add_sum;
  logic [2*XLEN-1:0]   acc_neg;
  logic [XLEN-1:0]     rem_neg_val, fix_res;

  assign o_ready = (state == ST_IDLE);
  assign o_valid = (state == ST_DONE);
  assign o_busy  = (state == ST_CALC) || (state == ST_FIX);

  // Request decode: operand signedness, magnitudes and no-iteration cases.
  always_comb begin
    op1_signed  = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                  (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    op2_signed  = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
    sgn1        = op1_signed && i_op1[XLEN-1];
    sgn2        = op2_signed && i_op2[XLEN-1];
    abs1        = sgn1 ? (~i_op1 + 32'd1) : i_op1;
    abs2        = sgn2 ? (~i_op2 + 32'd1) : i_op2;
    div_zero    = i_funct3[2] && (i_op2 == '0);
    div_ovf     = i_funct3[2] && !i_funct3[0] &&
                  (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
    req_special = div_zero || div_ovf || (EXTENSION_M == 32'd0);
    special_res = '0;
    if (EXTENSION_M != 32'd0) begin
      if (div_zero)     special_res = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
      else if (div_ovf) special_res = i_funct3[1] ? 32'h0 : 32'h8000_0000;
    end
  end

  // Shared 33-bit adder: add for shift-add multiply, subtract for restoring divide.
  always_comb begin
    is_div  = funct3_q[2];
    add_a   = is_div ? {acc[2*XLEN-1:XLEN], acc[XLEN-1]} : {1'b0, acc[2*XLEN-1:XLEN]};
    add_b   = {1'b0, (is_div || acc[0]) ? opb_q : 32'h0};
    add_sum = add_a + (is_div ? ~add_b : add_b) + AW'(is_div);
  end

  // Sign fix-up and result selection.
  always_comb begin
    acc_neg     = ~acc + 64'd1;
    rem_neg_val = ~acc[2*XLEN-1:XLEN] + 32'd1;
    fix_res     = '0;
    case (funct3_q)
      3'b000:                 fix_res = neg_q ? acc_neg[XLEN-1:0] : acc[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = neg_q ? acc_neg[XLEN-1:0] : acc[XLEN-1:0];
      default:                fix_res = rem_neg_q ? rem_neg_val : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      funct3_q  <= '0;
      acc       <= '0;
      opb_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      o_result  <= '0;
      o_rd      <= '0;
      o_pc      <= '0;
    end else if (i_flush) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      o_result <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            funct3_q  <= i_funct3;
            o_rd      <= i_rd;
            o_pc      <= i_pc;
            cnt       <= '0;
            neg_q     <= sgn1 ^ sgn2;
            rem_neg_q <= sgn1;
            acc       <= {32'h0, i_funct3[2] ? abs1 : abs2};
            opb_q     <= i_funct3[2] ? abs2 : abs1;
            if (req_special) begin
              o_result <= special_res;
              state    <= ST_DONE;
            end else begin
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (is_div) begin
            // Nonnegative trial difference commits a quotient 1.
            acc <= add_sum[AW-1] ? {acc[2*XLEN-2:0], 1'b0}
                                 : {add_sum[XLEN-1:0], acc[XLEN-2:0], 1'b1};
          end else begin
            acc <= {add_sum, acc[XLEN-1:1]};
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(31)) state <= ST_FIX;
        end
        ST_FIX: begin
          o_result <= fix_res;
          state    <= ST_DONE;
        end
        default: begin
          if (i_res_ready) begin
            o_result <= '0;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Self-checking bench for rv_muldiv_seq: directed cases plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_rv_muldiv_seq;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_flush;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_funct3;
  logic [31:0] i_op1;
  logic [31:0] i_op2;
  logic [4:0]  i_rd;
  logic [31:0] i_pc;
  logic        o_valid;
  logic        i_res_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic [31:0] o_pc;
  logic        o_busy;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 i_clk = ~i_clk;

  rv_muldiv_seq #(.EXTENSION_M(1), .IADDR_SPACE_BITS(32)) dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_funct3    (i_funct3),
    .i_op1       (i_op1),
    .i_op2       (i_op2),
    .i_rd        (i_rd),
    .i_pc        (i_pc),
    .o_valid     (o_valid),
    .i_res_ready (i_res_ready),
    .o_result    (o_result),
    .o_rd        (o_rd),
    .o_pc        (o_pc),
    .o_busy      (o_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural result of an RV32M operation.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] up, sp;
    bit          ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    up  = {32'h0, a} * {32'h0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: return up[31:0];
      3'd1: begin sp = 64'(sa * sb); return sp[63:32]; end
      3'd2: begin sp = 64'(sa * longint'({32'h0, b})); return sp[63:32]; end
      3'd3: return up[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && ((b == 0) ||
           (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Issue one request from IDLE, wait for the result, optionally stall, then hand off or flush.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] pc,
                        input int hold, input bit flush_done);
    int          n;
    int          lat;
    bit          busy_bad;
    bit          stable_bad;
    logic [31:0] exp;
    exp = ref_result(f3, a, b);
    lat = is_special(f3, a, b) ? 1 : 34;
    check("ready_before", o_ready, 1);
    i_valid = 1'b1; i_funct3 = f3; i_op1 = a; i_op2 = b; i_rd = rd; i_pc = pc;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0; i_op1 = $urandom; i_op2 = $urandom; i_rd = 5'($urandom); i_pc = $urandom;
    n = 1;
    busy_bad = 1'b0;
    while (o_valid !== 1'b1 && n < 80) begin
      if (o_busy !== 1'b1 || o_ready !== 1'b0) busy_bad = 1'b1;
      @(negedge i_clk);
      n++;
    end
    check("valid_seen", o_valid, 1);
    check("latency", n, lat);
    check("busy_during", busy_bad, 0);
    check("busy_done", o_busy, 0);
    check("result", o_result, exp);
    check("rd", o_rd, rd);
    check("pc", o_pc, pc);
    stable_bad = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge i_clk);
      if (o_valid !== 1'b1 || o_result !== exp || o_rd !== rd || o_pc !== pc || o_ready !== 1'b0)
        stable_bad = 1'b1;
    end
    if (hold > 0) check("backpressure_stable", stable_bad, 0);
    if (flush_done) i_flush = 1'b1;
    else            i_res_ready = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    i_res_ready = 1'b0;
    check("valid_after", o_valid, 0);
    check("ready_after", o_ready, 1);
    check("result_cleared", o_result, 0);
  endtask

  initial begin
    int          n;
    bit          vseen;
    logic [2:0]  f3;
    logic [31:0] a, b;

    i_reset_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_res_ready = 1'b0;
    i_funct3 = '0; i_op1 = '0; i_op2 = '0; i_rd = '0; i_pc = '0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_result", o_result, 0);
    check("rst_rd", o_rd, 0);
    check("rst_pc", o_pc, 0);
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Directed arithmetic cases.
    run_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5'd3,  32'h0000_1000, 0, 1'b0);
    check("mul_7_neg3", ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h0000_1004, 0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_1008, 0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'h0000_100C, 0, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'h0000_1010, 0, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'h0000_1014, 0, 1'b0);
    run_op(3'd5, 32'd100,       32'd7,         5'd9,  32'h0000_1018, 0, 1'b0);
    run_op(3'd7, 32'd100,       32'd7,         5'd10, 32'h0000_101C, 0, 1'b0);
    // Special cases complete one cycle after accept.
    run_op(3'd4, 32'd5,         32'd0,         5'd11, 32'h0000_1020, 0, 1'b0);
    run_op(3'd7, 32'd5,         32'd0,         5'd12, 32'h0000_1024, 0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_1028, 0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_102C, 0, 1'b0);
    // Backpressure: result held five extra cycles.
    run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98, 5'd15, 32'h0000_1030, 5, 1'b0);
    // Flush while the result waits in DONE discards it.
    run_op(3'd5, 32'd1000,      32'd9,         5'd16, 32'h0000_1034, 2, 1'b1);

    // Flush at cycle 10 of a DIV, then a MUL accepted on the next cycle.
    check("flush_ready_pre", o_ready, 1);
    i_valid = 1'b1; i_funct3 = 3'd4; i_op1 = 32'd1000; i_op2 = 32'd7; i_rd = 5'd20; i_pc = 32'h2000;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    n = 1;
    vseen = 1'b0;
    while (n < 10) begin
      if (o_valid !== 1'b0) vseen = 1'b1;
      @(negedge i_clk);
      n++;
    end
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    check("flush_no_valid", vseen, 0);
    check("flush_ready", o_ready, 1);
    check("flush_valid", o_valid, 0);
    check("flush_busy", o_busy, 0);
    run_op(3'd0, 32'd3, 32'd4, 5'd21, 32'h2004, 0, 1'b0);

    // Flush beats a simultaneous accept.
    i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_op1 = 32'd9; i_op2 = 32'd9;
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    check("flush_vs_accept_ready", o_ready, 1);
    check("flush_vs_accept_busy", o_busy, 0);
    repeat (3) @(negedge i_clk);
    check("flush_vs_accept_valid", o_valid, 0);

    // Randomized operations against the reference model.
    for (int k = 0; k < 24; k++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (k % 4 == 1) b = $urandom_range(1, 20);
      if (k % 6 == 0) b = 32'h0;
      if (k % 7 == 3) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(f3, a, b, 5'($urandom), $urandom, k % 3, 1'b0);
    end

    // Asynchronous reset in the middle of CALC.
    i_valid = 1'b1; i_funct3 = 3'd0; i_op1 = 32'd11; i_op2 = 32'd13; i_rd = 5'd30; i_pc = 32'h3000;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    check("pre_reset_busy", o_busy, 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("async_rst_busy", o_busy, 0);
    check("async_rst_valid", o_valid, 0);
    check("async_rst_ready", o_ready, 1);
    check("async_rst_result", o_result, 0);
    check("async_rst_rd", o_rd, 0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 5'd31, 32'h3004, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
